// File: rtl/move_entry_fsm_pkg.sv
// Shared types for the move-entry slice: square index, entry-state encoding
// and the {rank,file} square builder.
package chess_pkg;

  typedef logic [5:0] sq_t;

  typedef enum logic [1:0] {
    SEL_FROM = 2'b00,
    SEL_TO   = 2'b01,
    ISSUE    = 2'b10
  } entry_state_t;

  function automatic sq_t make_sq(input logic [2:0] rank, input logic [2:0] file);
    return {rank, file};
  endfunction

endpackage

// File: rtl/move_entry_fsm_if.sv
// Move handshake toward the board/rules stage: the assembled squares
// plus the valid/ack pair.
interface move_entry_fsm_if;
  import chess_pkg::*;

  sq_t  from_sq;
  sq_t  to_sq;
  logic move_valid;
  logic move_ack;

  modport master (output from_sq, output to_sq, output move_valid, input move_ack);
  modport slave  (input from_sq, input to_sq, input move_valid, output move_ack);

endinterface

// File: rtl/move_entry_fsm_button_conditioner.sv
// Raw button -> 2-flop sync -> stability debounce -> registered one-cycle
// press pulse on the debounced 0->1 transition.
module button_conditioner #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      level       <= 1'b0;
      level_d     <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      level_d     <= level;
      press_pulse <= level & ~level_d;
      // any sample agreeing with the accepted level restarts the stability window
      if (sync2 != level) begin
        if (cnt == CW'(DB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/move_entry_fsm.sv
// Builds a from/to square pair from cursor position and confirm/cancel presses,
// then presents it downstream until acknowledged or cancelled.
//   state    | meaning
//   SEL_FROM | waiting for confirm to latch the source square
//   SEL_TO   | waiting for confirm (destination) or cancel
//   ISSUE    | move_valid high, waiting for ack or cancel
module move_entry_fsm
  import chess_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         file_in,
  input  logic [2:0]         rank_in,
  input  logic               confirm_btn,
  input  logic               cancel_btn,
  move_entry_fsm_if.master   mv,
  output logic               reject,
  output logic [1:0]         sel_state
);

  logic         confirm_p;
  logic         cancel_p;
  entry_state_t state_q, state_nx;
  sq_t          from_q, from_nx;
  sq_t          to_q, to_nx;
  logic         valid_q, valid_nx;
  logic         reject_q, reject_nx;
  sq_t          cursor;

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_confirm (
    .clk         (clk),
    .reset       (reset),
    .raw         (confirm_btn),
    .press_pulse (confirm_p)
  );

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cancel (
    .clk         (clk),
    .reset       (reset),
    .raw         (cancel_btn),
    .press_pulse (cancel_p)
  );

  assign cursor = make_sq(rank_in, file_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEL_FROM;
      from_q   <= '0;
      to_q     <= '0;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_nx;
      from_q   <= from_nx;
      to_q     <= to_nx;
      valid_q  <= valid_nx;
      reject_q <= reject_nx;
    end
  end

  always_comb begin
    state_nx  = state_q;
    from_nx   = from_q;
    to_nx     = to_q;
    valid_nx  = valid_q;
    reject_nx = 1'b0;
    unique case (state_q)
      SEL_FROM: begin
        if (confirm_p) begin
          from_nx  = cursor;
          state_nx = SEL_TO;
        end
      end
      SEL_TO: begin
        // cancel outranks a simultaneous confirm
        if (cancel_p) begin
          state_nx = SEL_FROM;
        end else if (confirm_p) begin
          if (cursor == from_q) begin
            reject_nx = 1'b1;
          end else begin
            to_nx    = cursor;
            valid_nx = 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mv.move_ack || cancel_p) begin
          valid_nx = 1'b0;
          state_nx = SEL_FROM;
        end
      end
      default: state_nx = SEL_FROM;
    endcase
  end

  assign mv.from_sq    = from_q;
  assign mv.to_sq      = to_q;
  assign mv.move_valid = valid_q;
  assign reject        = reject_q;
  assign sel_state     = state_q;

endmodule

// File: tb/tb_move_entry_fsm.sv
// Directed bench for move_entry_fsm with DB_CYCLES=4; presented moves are
// checked against a scoreboard queue filled when the destination press is driven.
module tb_move_entry_fsm;
  import chess_pkg::*;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] file_in;
  logic [2:0] rank_in;
  logic       confirm_btn;
  logic       cancel_btn;
  logic       reject;
  logic [1:0] sel_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic        mv_prev = 1'b0;

  move_entry_fsm_if mv_if ();

  move_entry_fsm #(.DB_CYCLES(DB)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .file_in     (file_in),
    .rank_in     (rank_in),
    .confirm_btn (confirm_btn),
    .cancel_btn  (cancel_btn),
    .mv          (mv_if.master),
    .reject      (reject),
    .sel_state   (sel_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: each rising move_valid must match the oldest expected move
  always @(negedge clk) begin
    if (mv_if.move_valid && !mv_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_move", 32'(mv_if.move_valid), 32'd0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("sb_move", 32'({mv_if.from_sq, mv_if.to_sq}), 32'(e));
      end
    end
    mv_prev <= mv_if.move_valid;
  end

  task automatic press_confirm(input logic [2:0] r, input logic [2:0] f);
    rank_in = r;
    file_in = f;
    confirm_btn = 1'b1;
    repeat (12) tick();
    confirm_btn = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    reset = 1'b1;
    file_in = '0;
    rank_in = '0;
    confirm_btn = 1'b0;
    cancel_btn = 1'b0;
    mv_if.move_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_state", 32'(sel_state), 32'd0);
    chk("rst_from", 32'(mv_if.from_sq), 32'd0);
    chk("rst_to", 32'(mv_if.to_sq), 32'd0);
    chk("rst_valid", 32'(mv_if.move_valid), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);

    // 1: first press latches source square 11
    file_in = 3'd3;
    rank_in = 3'd1;
    confirm_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("t1_pulse_e%0d", k), 32'(u_dut.u_confirm.press_pulse), 32'(k == 7));
      if (k == 8) begin
        chk("t1_state", 32'(sel_state), 32'd1);
        chk("t1_from", 32'(mv_if.from_sq), 32'd11);
      end
    end
    confirm_btn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t1_release_nopulse", 32'(u_dut.u_confirm.press_pulse), 32'd0);
    end

    // 2: destination 53, hold without ack, then ack
    exp_q.push_back({6'd11, 6'd53});
    press_confirm(3'd6, 3'd5);
    chk("t2_to", 32'(mv_if.to_sq), 32'd53);
    chk("t2_valid", 32'(mv_if.move_valid), 32'd1);
    chk("t2_state", 32'(sel_state), 32'd2);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t2_hold", 32'({sel_state, mv_if.move_valid, mv_if.from_sq, mv_if.to_sq}),
          32'({2'd2, 1'b1, 6'd11, 6'd53}));
    end
    mv_if.move_ack = 1'b1;
    tick();
    mv_if.move_ack = 1'b0;
    chk("t2_ack_valid", 32'(mv_if.move_valid), 32'd0);
    chk("t2_ack_state", 32'(sel_state), 32'd0);

    // 3: bouncing confirm never debounces
    for (int k = 0; k < 40; k++) begin
      confirm_btn = (k < 30) ? logic'((k / 2) % 2) : 1'b0;
      tick();
      chk("t3_nopulse", 32'(u_dut.u_confirm.press_pulse), 32'd0);
    end
    chk("t3_state", 32'(sel_state), 32'd0);
    chk("t3_squares", 32'({mv_if.from_sq, mv_if.to_sq}), 32'({6'd11, 6'd53}));

    // 4: destination equal to source is rejected
    press_confirm(3'd1, 3'd3);
    chk("t4_state_pre", 32'(sel_state), 32'd1);
    confirm_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("t4_reject_e%0d", k), 32'(reject), 32'(k == 8));
      chk("t4_state", 32'(sel_state), 32'd1);
      chk("t4_valid", 32'(mv_if.move_valid), 32'd0);
    end
    confirm_btn = 1'b0;
    repeat (10) tick();

    // 5a: confirm and cancel together in SEL_TO -> cancel wins
    file_in = 3'd0;
    confirm_btn = 1'b1;
    cancel_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t5_noreject", 32'(reject), 32'd0);
      chk("t5_novalid", 32'(mv_if.move_valid), 32'd0);
    end
    chk("t5_state", 32'(sel_state), 32'd0);
    chk("t5_from_stale", 32'(mv_if.from_sq), 32'd11);
    confirm_btn = 1'b0;
    cancel_btn = 1'b0;
    repeat (10) tick();

    // 5b: cancel coincident with ack in ISSUE
    press_confirm(3'd0, 3'd2);
    exp_q.push_back({6'd2, 6'd63});
    press_confirm(3'd7, 3'd7);
    chk("t5b_state_pre", 32'(sel_state), 32'd2);
    cancel_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      mv_if.move_ack = (k == 7);
      if (k == 8) begin
        chk("t5b_valid", 32'(mv_if.move_valid), 32'd0);
        chk("t5b_state", 32'(sel_state), 32'd0);
        chk("t5b_to", 32'(mv_if.to_sq), 32'd63);
      end
    end
    cancel_btn = 1'b0;
    repeat (10) tick();

    // 6: reset while in ISSUE with confirm held
    press_confirm(3'd1, 3'd1);
    exp_q.push_back({6'd9, 6'd36});
    press_confirm(3'd4, 3'd4);
    chk("t6_state_pre", 32'(sel_state), 32'd2);
    reset = 1'b1;
    confirm_btn = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_valid", 32'(mv_if.move_valid), 32'd0);
    chk("t6_rst_from", 32'(mv_if.from_sq), 32'd0);
    chk("t6_rst_to", 32'(mv_if.to_sq), 32'd0);
    chk("t6_rst_reject", 32'(reject), 32'd0);
    chk("t6_rst_state", 32'(sel_state), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("t6_pulse_e%0d", k), 32'(u_dut.u_confirm.press_pulse), 32'(k == 7));
      if (k == 8) begin
        chk("t6_state", 32'(sel_state), 32'd1);
        chk("t6_from", 32'(mv_if.from_sq), 32'd36);
      end
    end
    confirm_btn = 1'b0;
    repeat (4) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/move_entry_fsm.md
Name: move_entry_fsm

Overview:
- Downstream consumer of the 3-bit file and rank cursor counters.
- Assembles a chess move as a from-square and a to-square, driven by debounced confirm/cancel buttons.
- Presents the move to the board/rules stage over a valid/ack handshake.
- Sits between the cursor counters and the board-state logic.

Parameters:
- DB_CYCLES, default 500000, number of consecutive stable synchronized samples needed before a button level is accepted (bench overrides to 4).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- file_in  input  3  cursor column from the file counter.
- rank_in  input  3  cursor row from the rank counter.
- confirm_btn  input  1  raw asynchronous confirm button.
- cancel_btn  input  1  raw asynchronous cancel button.
- move_ack  input  1  downstream accepts the presented move.
- from_sq  output  6  latched source square {rank,file}.
- to_sq  output  6  latched destination square {rank,file}.
- move_valid  output  1  move presented; held until ack or cancel.
- reject  output  1  one-cycle pulse when the destination equals the source.
- sel_state  output  2  current state code, for LEDs.

Behaviour:
- Reset (synchronous, active-high): state SEL_FROM. from_sq=0, to_sq=0, move_valid=0, reject=0. Synchronizers, debounce counters and debounced levels all cleared to 0.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Counter increments each cycle the synchronized value differs from the debounced level, and clears on any cycle they match.
  - When the counter would reach DB_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - Press pulse is registered: one cycle high on a debounced 0->1 transition.
  - Raw rise held stable from edge 0 gives a pulse high after edge DB_CYCLES+3.
  - Release generates nothing.
  - A button held through reset yields one press after DB_CYCLES+3 edges.
- State encoding: SEL_FROM=2'b00, SEL_TO=2'b01, ISSUE=2'b10. 2'b11 is illegal and goes to SEL_FROM on the next edge. sel_state equals the state register.
- SEL_FROM:
  - confirm press: from_sq<={rank_in,file_in}, go to SEL_TO.
  - cancel and move_ack ignored.
- SEL_TO:
  - cancel press: go to SEL_FROM. from_sq keeps its stale value.
  - confirm press with {rank_in,file_in}==from_sq: reject=1 for one cycle, stay in SEL_TO.
  - other confirm press: to_sq<={rank_in,file_in}, move_valid<=1, go to ISSUE.
  - confirm and cancel in the same cycle: cancel wins, no reject, no latch.
- ISSUE:
  - move_valid=1; from_sq and to_sq held stable.
  - move_ack=1: move_valid<=0, go to SEL_FROM.
  - cancel press: move_valid<=0, go to SEL_FROM.
  - ack and cancel in the same cycle: ack wins (move consumed; outcome is identical).
  - confirm press ignored.
- move_ack outside ISSUE is ignored.
- Latencies:
  - Press pulse to state/register update: 1 edge.
  - Ack to move_valid low: 1 edge.
  - No combinational path from any input to any output.
- Width rule: square index = rank*8+file, i.e. {rank_in,file_in}, range 0..63. No arithmetic overflow is possible.
- Counters wrapping 7->0 upstream need no special handling; the cursor value is sampled only on a press.

Decomposition:
- Package chess_pkg holds:
  - typedef sq_t (logic [5:0]).
  - Enum entry_state_t (SEL_FROM, SEL_TO, ISSUE) with the explicit 2-bit encodings above.
  - Function make_sq(rank, file).
- One sub-module: button_conditioner, parameter DB_CYCLES. Ports clk, reset, raw, press_pulse. Instantiated twice.

Test Plan (DB_CYCLES=4):
1. Reset, then file_in=3, rank_in=1, raw confirm held high 12 cycles.
   - Press pulse after edge 7.
   - Next edge: sel_state=01, from_sq=11.
   - Exactly one press.
2. From test 1, file_in=5, rank_in=6, confirm press.
   - to_sq=53, move_valid=1, sel_state=10.
   - move_ack=0 for 20 cycles: all outputs stable.
   - 1-cycle ack: move_valid=0 and sel_state=00 on the next edge.
3. Raw confirm toggling every 2 cycles for 30 cycles, then low for 10.
   - No press pulse; sel_state and squares unchanged.
4. In SEL_TO with from_sq=11 and cursor still file=3, rank=1, confirm press.
   - reject high exactly 1 cycle, sel_state stays 01, move_valid=0.
5. In SEL_TO, confirm and cancel raw rise on the same edge.
   - sel_state=00, move_valid never asserts, no reject.
   - Separately, in ISSUE, cancel pulse coincident with ack: move_valid=0, sel_state=00, to_sq retains its value.
6. reset asserted for 1 cycle while in ISSUE.
   - Next edge: move_valid=0, from_sq=0, to_sq=0, reject=0, sel_state=00.
   - Confirm still held afterwards: one fresh press after DB_CYCLES+3 edges.
